// File: rtl/alu_core_param.sv
// alu_core_param: parametrised execute core (register file, pc in r15, ALU, branch unit, I/O handshakes).
// Define ALU_MUL_EN to make opcode F a single-cycle MUL; otherwise opcode F is a NOP.
module alu_core_param #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 10,
    parameter int LED_W  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       instruction,
    output logic [DATA_W-1:0] pc,
    input  logic [IN_W-1:0]   in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] display,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [LED_W-1:0]  led,
    output logic              halted
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] SH_LIMIT = DATA_W'(DATA_W);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    typedef enum logic [1:0] {RUN, WAIT_IN, WAIT_OUT, HALT} state_t;

    typedef enum logic [3:0] {
        OP_LI   = 4'h0, OP_IO   = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
        OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_SL   = 4'h7,
        OP_SR   = 4'h8, OP_SA   = 4'h9, OP_BG   = 4'hA, OP_BL   = 4'hB,
        OP_BE   = 4'hC, OP_LIH  = 4'hD, OP_HALT = 4'hE, OP_EXT  = 4'hF
    } opcode_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] rf [16];

    opcode_t op;
    logic [3:0] rd, rs1, rs2;
    logic [7:0] imm;

    logic [DATA_W-1:0] a, b, rd_val, pc_inc;
    logic [DATA_W-1:0] alu_res, wr_data, pc_d, display_d;
    logic signed [DATA_W-1:0] sa_res;
    logic [SH_W-1:0] sh;
    logic sh_big, br_taken, wr_en, dv_d;
    logic [15:0] we;

    assign op  = opcode_t'(instruction[15:12]);
    assign rd  = instruction[11:8];
    assign rs1 = instruction[7:4];
    assign rs2 = instruction[3:0];
    assign imm = instruction[7:0];

    assign a      = rf[rs1];
    assign b      = rf[rs2];
    assign rd_val = rf[rd];
    assign pc     = rf[15];
    assign pc_inc = rf[15] + ONE;

    // Shift amount is the whole register; anything >= DATA_W saturates.
    assign sh_big = (b >= SH_LIMIT);
    assign sh     = b[SH_W-1:0];
    assign sa_res = $signed(a) >>> sh;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_LI:  alu_res = DATA_W'(imm);
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SL:  alu_res = sh_big ? '0 : (a << sh);
            OP_SR:  alu_res = sh_big ? '0 : (a >> sh);
            OP_SA:  alu_res = sh_big ? {DATA_W{a[DATA_W-1]}} : sa_res;
            OP_LIH: begin
                alu_res       = rd_val;
                alu_res[15:8] = imm;
            end
`ifdef ALU_MUL_EN
            OP_EXT: alu_res = a * b;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (op)
            OP_BG:   br_taken = (a > b);
            OP_BL:   br_taken = (a < b);
            OP_BE:   br_taken = (a == b);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_data   = alu_res;
        pc_d      = rf[15];
        display_d = display;
        // A pending display retires on handshake unless reloaded below.
        dv_d      = disp_valid & ~disp_ready;

        case (state_q)
            RUN: begin
                case (op)
                    OP_LI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_SL, OP_SR, OP_SA, OP_LIH: begin
                        wr_en = 1'b1;
                        pc_d  = (rd == 4'hF) ? alu_res : pc_inc;
                    end
                    OP_IO: begin
                        if (imm == 8'h00) begin
                            if (disp_valid && !disp_ready) begin
                                state_d = WAIT_OUT;
                            end else begin
                                display_d = rd_val;
                                dv_d      = 1'b1;
                                pc_d      = pc_inc;
                            end
                        end else begin
                            state_d = WAIT_IN;
                        end
                    end
                    OP_BG, OP_BL, OP_BE: pc_d = br_taken ? rd_val : pc_inc;
                    OP_HALT: state_d = HALT;
                    OP_EXT: begin
`ifdef ALU_MUL_EN
                        wr_en = 1'b1;
                        pc_d  = (rd == 4'hF) ? alu_res : pc_inc;
`else
                        pc_d  = pc_inc;
`endif
                    end
                    default: pc_d = pc_inc;
                endcase
            end
            WAIT_IN: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = DATA_W'(in);
                    pc_d    = (rd == 4'hF) ? DATA_W'(in) : pc_inc;
                    state_d = RUN;
                end
            end
            WAIT_OUT: begin
                if (disp_ready) begin
                    display_d = rd_val;
                    dv_d      = 1'b1;
                    pc_d      = pc_inc;
                    state_d   = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        we = '0;
        if (wr_en) we[rd] = 1'b1;
    end

    // r15 is owned by pc_d; writes addressed to r15 are already folded into it.
    always_ff @(negedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            display    <= '0;
            disp_valid <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            state_q    <= state_d;
            display    <= display_d;
            disp_valid <= dv_d;
            for (int unsigned i = 0; i < 16; i++) begin
                if (i == 15) rf[i] <= pc_d;
                else if (we[i]) rf[i] <= wr_data;
            end
        end
    end

    assign in_ready = (state_q == WAIT_IN);
    assign halted   = (state_q == HALT);
    assign led      = (state_q == WAIT_IN) ? '1 : '0;

endmodule

// File: tb/tb_alu_core_param.sv
// Directed, table-driven bench for alu_core_param (DATA_W=16, IN_W=10, LED_W=10).
// Inputs change just after the falling edge; outputs are checked 2 time units after it.
module tb_alu_core_param;

    logic        clock;
    logic        reset;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic [9:0]  in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] display;
    logic        disp_valid;
    logic        disp_ready;
    logic [9:0]  led;
    logic        halted;

    int n_vec = 0;
    int n_bad = 0;

`ifdef ALU_MUL_EN
    localparam logic [15:0] MUL_EXP = 16'h13EC;
`else
    localparam logic [15:0] MUL_EXP = 16'h0000;
`endif

    alu_core_param #(.DATA_W(16), .IN_W(10), .LED_W(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .pc          (pc),
        .in          (in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .display     (display),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .led         (led),
        .halted      (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic        dvld;
        logic        drdy;
        logic [15:0] e_pc;
        logic [15:0] e_disp;
        logic        e_dv;
        logic        e_ir;
        logic        e_halt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [15:0] ins, input logic dvld,
                       input logic drdy, input logic [15:0] e_pc, input logic [15:0] e_disp,
                       input logic e_dv, input logic e_ir, input logic e_halt);
        vec_t v;
        v.rst = rst; v.ins = ins; v.dvld = dvld; v.drdy = drdy;
        v.e_pc = e_pc; v.e_disp = e_disp; v.e_dv = e_dv; v.e_ir = e_ir; v.e_halt = e_halt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [15:0] ins, input logic [9:0] din,
                         input logic dvld, input logic drdy);
        reset       = rst;
        instruction = ins;
        in          = din;
        in_valid    = dvld;
        disp_ready  = drdy;
        @(negedge clock);
        #2;
    endtask

    task automatic check(input string name, input logic [15:0] e_pc, input logic [15:0] e_disp,
                         input logic e_dv, input logic e_ir, input logic e_halt);
        logic [9:0] e_led;
        e_led = e_ir ? 10'h3FF : 10'h000;
        n_vec++;
        if ({pc, display, disp_valid, in_ready, led, halted} !==
            {e_pc, e_disp, e_dv, e_ir, e_led, e_halt}) begin
            n_bad++;
            $display("FAIL %s: got pc=%h disp=%h dv=%b ir=%b led=%h halt=%b, want pc=%h disp=%h dv=%b ir=%b led=%h halt=%b",
                     name, pc, display, disp_valid, in_ready, led, halted,
                     e_pc, e_disp, e_dv, e_ir, e_led, e_halt);
        end
    endtask

    initial begin
        reset = 1'b1; instruction = '0; in = '0; in_valid = 1'b0; disp_ready = 1'b1;

        //   rst  ins       dvld drdy  pc        disp      dv   ir   halt
        add(1, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 16'h015A, 0, 1, 16'h0001, 16'h0000, 0, 0, 0); // LI r1,5A
        add(0, 16'h0203, 0, 1, 16'h0002, 16'h0000, 0, 0, 0); // LI r2,3
        add(0, 16'h03FF, 0, 1, 16'h0003, 16'h0000, 0, 0, 0); // LI r3,FF
        add(0, 16'hD380, 0, 1, 16'h0004, 16'h0000, 0, 0, 0); // LIH r3 -> 80FF
        add(0, 16'h9432, 0, 1, 16'h0005, 16'h0000, 0, 0, 0); // SA r4 = F01F
        add(0, 16'h7732, 0, 1, 16'h0006, 16'h0000, 0, 0, 0); // SL r7 = 07F8
        add(0, 16'h8832, 0, 1, 16'h0007, 16'h0000, 0, 0, 0); // SR r8 = 101F
        add(0, 16'h1400, 0, 1, 16'h0008, 16'hF01F, 1, 0, 0);
        add(0, 16'h1700, 0, 1, 16'h0009, 16'h07F8, 1, 0, 0); // handshake + reload
        add(0, 16'h1800, 0, 1, 16'h000A, 16'h101F, 1, 0, 0);
        add(0, 16'h0214, 0, 1, 16'h000B, 16'h101F, 0, 0, 0); // LI r2,20
        add(0, 16'h9432, 0, 1, 16'h000C, 16'h101F, 0, 0, 0); // SA -> FFFF
        add(0, 16'h7732, 0, 1, 16'h000D, 16'h101F, 0, 0, 0); // SL -> 0
        add(0, 16'h8832, 0, 1, 16'h000E, 16'h101F, 0, 0, 0); // SR -> 0
        add(0, 16'h1700, 0, 1, 16'h000F, 16'h0000, 1, 0, 0);
        add(0, 16'h1400, 0, 1, 16'h0010, 16'hFFFF, 1, 0, 0);
        add(0, 16'h1800, 0, 1, 16'h0011, 16'h0000, 1, 0, 0);
        add(0, 16'h0A01, 0, 1, 16'h0012, 16'h0000, 0, 0, 0); // LI r10,1
        add(0, 16'h1A00, 0, 1, 16'h0013, 16'h0001, 1, 0, 0);
        add(0, 16'h214A, 0, 1, 16'h0014, 16'h0001, 0, 0, 0); // ADD r1 = FFFF+1
        add(0, 16'h1100, 0, 1, 16'h0015, 16'h0000, 1, 0, 0);
        add(0, 16'h3B1A, 0, 1, 16'h0016, 16'h0000, 0, 0, 0); // SUB r11 = 0-1
        add(0, 16'h1B00, 0, 1, 16'h0017, 16'hFFFF, 1, 0, 0);
        add(0, 16'h6C34, 0, 1, 16'h0018, 16'hFFFF, 0, 0, 0); // XOR r12 = 7F00
        add(0, 16'h1C00, 0, 1, 16'h0019, 16'h7F00, 1, 0, 0);
        add(0, 16'h4D32, 0, 1, 16'h001A, 16'h7F00, 0, 0, 0); // AND r13 = 0014
        add(0, 16'h5EC2, 0, 1, 16'h001B, 16'h7F00, 0, 0, 0); // OR r14 = 7F14
        add(0, 16'h1D00, 0, 1, 16'h001C, 16'h0014, 1, 0, 0);
        add(0, 16'h1E00, 0, 1, 16'h001D, 16'h7F14, 1, 0, 0);
        add(0, 16'h1501, 0, 1, 16'h001D, 16'h7F14, 0, 1, 0); // IO in r5, wait
        add(0, 16'h1501, 0, 1, 16'h001D, 16'h7F14, 0, 1, 0);
        add(0, 16'h1501, 0, 1, 16'h001D, 16'h7F14, 0, 1, 0);
        add(0, 16'h1501, 0, 1, 16'h001D, 16'h7F14, 0, 1, 0);
        add(0, 16'h1501, 1, 1, 16'h001E, 16'h7F14, 0, 0, 0); // r5 = 155
        add(0, 16'h1500, 0, 1, 16'h001F, 16'h0155, 1, 0, 0);
        add(0, 16'h0000, 0, 1, 16'h0020, 16'h0155, 0, 0, 0);
        add(0, 16'h1C00, 0, 0, 16'h0021, 16'h7F00, 1, 0, 0); // first out
        add(0, 16'h1E00, 0, 0, 16'h0021, 16'h7F00, 1, 0, 0); // WAIT_OUT
        add(0, 16'h1E00, 0, 0, 16'h0021, 16'h7F00, 1, 0, 0);
        add(0, 16'h1E00, 0, 1, 16'h0022, 16'h7F14, 1, 0, 0); // accepted
        add(0, 16'h0000, 0, 1, 16'h0023, 16'h7F14, 0, 0, 0);
        add(0, 16'h0610, 0, 1, 16'h0024, 16'h7F14, 0, 0, 0); // LI r6,10
        add(0, 16'hC611, 0, 1, 16'h0010, 16'h7F14, 0, 0, 0); // BE taken
        add(0, 16'hA612, 0, 1, 16'h0011, 16'h7F14, 0, 0, 0); // BG not taken
        add(0, 16'hB612, 0, 1, 16'h0010, 16'h7F14, 0, 0, 0); // BL taken
        add(0, 16'hA621, 0, 1, 16'h0010, 16'h7F14, 0, 0, 0); // BG taken
        add(0, 16'hC612, 0, 1, 16'h0011, 16'h7F14, 0, 0, 0); // BE not taken
        add(0, 16'h2F66, 0, 1, 16'h0020, 16'h7F14, 0, 0, 0); // ADD r15 jump
        add(0, 16'h0F80, 0, 1, 16'h0080, 16'h7F14, 0, 0, 0); // LI r15 jump
        add(0, 16'hF932, 0, 1, 16'h0081, 16'h7F14, 0, 0, 0); // opcode F
        add(0, 16'h1900, 0, 1, 16'h0082, MUL_EXP,  1, 0, 0);
        add(0, 16'h0FFF, 0, 1, 16'h00FF, MUL_EXP,  0, 0, 0);
        add(0, 16'hDFFF, 0, 1, 16'hFFFF, MUL_EXP,  0, 0, 0); // LIH r15
        add(0, 16'h0000, 0, 1, 16'h0000, MUL_EXP,  0, 0, 0); // pc wraps
        add(0, 16'h1300, 0, 0, 16'h0001, 16'h80FF, 1, 0, 0);
        add(0, 16'hE000, 0, 0, 16'h0001, 16'h80FF, 1, 0, 1); // HALT
        add(0, 16'h0F33, 0, 0, 16'h0001, 16'h80FF, 1, 0, 1);
        add(0, 16'h0F33, 0, 0, 16'h0001, 16'h80FF, 1, 0, 1);
        add(0, 16'h0F33, 0, 0, 16'h0001, 16'h80FF, 1, 0, 1);
        add(0, 16'h0F33, 0, 0, 16'h0001, 16'h80FF, 1, 0, 1);
        add(0, 16'h0F33, 0, 1, 16'h0001, 16'h80FF, 0, 0, 1); // handshake in HALT
        add(1, 16'h0F33, 0, 1, 16'h0000, 16'h0000, 0, 0, 0); // reset exits HALT

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ins, 10'h155, tbl[i].dvld, tbl[i].drdy);
            check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_disp,
                  tbl[i].e_dv, tbl[i].e_ir, tbl[i].e_halt);
        end

        // Reset while waiting for input.
        drive(0, 16'h1501, 10'h155, 0, 1);
        check("wait_in_enter", 16'h0000, 16'h0000, 0, 1, 0);
        drive(1, 16'h1501, 10'h155, 0, 1);
        check("wait_in_reset", 16'h0000, 16'h0000, 0, 0, 0);

        // Reset while stalled on output discards the pending display.
        drive(0, 16'h0577, 10'h000, 0, 1);
        check("li_r5", 16'h0001, 16'h0000, 0, 0, 0);
        drive(0, 16'h1500, 10'h000, 0, 0);
        check("out_r5", 16'h0002, 16'h0077, 1, 0, 0);
        drive(0, 16'h1500, 10'h000, 0, 0);
        check("wait_out_enter", 16'h0002, 16'h0077, 1, 0, 0);
        drive(1, 16'h1500, 10'h000, 0, 0);
        check("wait_out_reset", 16'h0000, 16'h0000, 0, 0, 0);
        drive(0, 16'h1500, 10'h000, 0, 0);
        check("out_after_reset", 16'h0001, 16'h0000, 1, 0, 0);

        // IO input into r15 loads pc directly; in_valid raised only once in_ready is seen.
        drive(0, 16'h1F01, 10'h2AA, 0, 1);
        begin
            int k;
            k = 0;
            while (!in_ready && k < 8) begin
                drive(0, 16'h1F01, 10'h2AA, 0, 1);
                k++;
            end
            if (!in_ready) begin
                n_vec++;
                n_bad++;
                $display("FAIL in_ready_timeout: got in_ready=%b, want 1 within 8 cycles", in_ready);
            end
        end
        check("wait_in_r15", 16'h0001, 16'h0000, 0, 1, 0);
        drive(0, 16'h1F01, 10'h2AA, 1, 1);
        check("in_to_pc", 16'h02AA, 16'h0000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
